data_mem_responder: RTL

- Responder end of the datapath's load/store interface: a 256-byte data memory serving word and byte requests from the core over a four-phase req/ack handshake.
- Adds a configurable number of wait states so the core's stall logic can be exercised against slow memory.
- Sits beside the register file and ALU.
  - ALU result supplies the address.
  - Register read data supplies the store data.
  - Returned word/byte feeds the load mux into the register write-back path.

---
 rtl/data_mem_responder.sv | 121 ++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module      : data_mem_responder
// Description : 256-byte data memory answering word/byte load-store requests
//               over a four-phase req/ack handshake, with programmable wait
//               states ahead of the access.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH       = 256
) (
  input  logic        CLOCK,
  input  logic        CLEAR,
  input  logic        req,
  input  logic        we,
  input  logic        byte_op,
  input  logic [7:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata_word,
  output logic [7:0]  rdata_byte,
  output logic        ack,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_ack;
  logic        r_busy;
  logic [15:0] r_rdata_word;
  logic [7:0]  r_rdata_byte;
  logic [7:0]  r_addr;
  logic        r_we;
  logic        r_byte_op;
  logic [15:0] r_wdata;
  logic [7:0]  r_mem [DEPTH];
  logic [7:0]  w_a0;
  logic [7:0]  w_a1;

  // Word accesses use the byte pair (a, a+1) with wrap, high byte first.
  assign w_a0 = 8'(32'(r_addr) % 32'(DEPTH));
  assign w_a1 = 8'((32'(r_addr) + 32'd1) % 32'(DEPTH));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (req) w_next = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
      S_WAIT:   if (r_cnt == 4'd1) w_next = S_ACCESS;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   if (!req) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge CLEAR) begin
    if (!CLEAR) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_ack        <= 1'b0;
      r_busy       <= 1'b0;
      r_rdata_word <= 16'h0000;
      r_rdata_byte <= 8'h00;
      r_addr       <= 8'h00;
      r_we         <= 1'b0;
      r_byte_op    <= 1'b0;
      r_wdata      <= 16'h0000;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else begin
      r_state <= w_next;
      r_ack   <= (w_next == S_RESP);
      r_busy  <= (w_next != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_addr    <= addr;
            r_we      <= we;
            r_byte_op <= byte_op;
            r_wdata   <= wdata;
            r_cnt     <= 4'(WAIT_CYCLES);
          end
        end
        S_WAIT: r_cnt <= r_cnt - 4'd1;
        S_ACCESS: begin
          // Stores never touch the read registers; each load kind owns its own.
          if (r_we) begin
            if (r_byte_op) begin
              r_mem[w_a0] <= r_wdata[7:0];
            end else begin
              r_mem[w_a0] <= r_wdata[15:8];
              r_mem[w_a1] <= r_wdata[7:0];
            end
          end else if (r_byte_op) begin
            r_rdata_byte <= r_mem[w_a0];
          end else begin
            r_rdata_word <= {r_mem[w_a0], r_mem[w_a1]};
          end
        end
        default: ;
      endcase
    end
  end

  assign ack        = r_ack;
  assign busy       = r_busy;
  assign rdata_word = r_rdata_word;
  assign rdata_byte = r_rdata_byte;

endmodule

`default_nettype wire
